// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer and its helpers.
package melody_pkg;

  localparam logic [6:0] REST_CODE = 7'd127;
  localparam logic [6:0] NOTE_MAX  = 7'd28;

  localparam int unsigned DUR_W_DEF = 10;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StPlay,
    StGap
  } state_e;

  typedef struct packed {
    logic [6:0]           note;
    logic [DUR_W_DEF-1:0] dur;
  } entry_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/melody_sequencer.sv
// Steps through a host-written (note, duration) table and drives the tone generator.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned DUR_W     = 10,
  parameter int unsigned GAP_TICKS = 10,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [6:0]       wr_note,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  output logic [6:0]       note_code,
  output logic             tone_en,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    cur_addr
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [DUR_W-1:0] GAP_LAST = (GAP_TICKS == 0) ? '0 : DUR_W'(GAP_TICKS - 1);

  typedef struct packed {
    logic [6:0]       note;
    logic [DUR_W-1:0] dur;
  } table_entry_t;

  state_e         state_q, state_d;
  logic [AW-1:0]    cur_addr_q, cur_addr_d;
  logic [DUR_W-1:0] tcnt_q, tcnt_d;
  logic [6:0]       note_code_q;
  logic             done_q, done_d;
  logic             tick, step, end_seq;
  table_entry_t     mem_q [DEPTH];
  table_entry_t     rd_entry, cur_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= '{note: wr_note, dur: wr_dur};
    end
  end

  assign rd_entry = mem_q[cur_addr_q];

  // Any state change restarts the tick phase so every duration is exact.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_d != state_q),
    .enable  ((state_q == StPlay) || (state_q == StGap)),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      tcnt_q      <= '0;
      cur_q       <= '0;
      note_code_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      tcnt_q     <= tcnt_d;
      done_q     <= done_d;
      if (state_q == StFetch) begin
        cur_q <= rd_entry;
      end
      // A rest leaves the generator on its previous note.
      if (state_q == StFetch && state_d == StPlay && rd_entry.note != REST_CODE) begin
        note_code_q <= rd_entry.note;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    tcnt_d     = tcnt_q;
    done_d     = 1'b0;
    step       = 1'b0;
    end_seq    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d    = StFetch;
          cur_addr_d = '0;
        end
      end
      StFetch: begin
        tcnt_d = '0;
        if (rd_entry.dur != '0) state_d = StPlay;
        else                    end_seq = 1'b1;
      end
      StPlay: begin
        if (tick) begin
          if (tcnt_q == cur_q.dur - 1'b1) begin
            tcnt_d = '0;
            if (GAP_TICKS == 0) step = 1'b1;
            else                state_d = StGap;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      StGap: begin
        if (tick) begin
          if (tcnt_q == GAP_LAST) begin
            tcnt_d = '0;
            step   = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
    endcase

    if (step) begin
      if (cur_addr_q == LAST_ADDR) begin
        end_seq = 1'b1;
      end else begin
        cur_addr_d = cur_addr_q + 1'b1;
        state_d    = StFetch;
      end
    end

    // An empty table (marker at address 0) never wraps, even with loop_en.
    if (end_seq) begin
      if (loop_en && cur_addr_q != '0) begin
        cur_addr_d = '0;
        state_d    = StFetch;
      end else begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end

    if (stop && state_q != StIdle) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    tone_en   = (state_q == StPlay) && (cur_q.note != REST_CODE);
    note_code = note_code_q;
    done      = done_q;
    cur_addr  = cur_addr_q;
  end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a stored melody on the tone generator. It holds a table of (note, duration) entries written by the host, steps through it at a fixed duration tick, and drives the tone generator's note index together with a tone-enable gate. It sits between the host/control logic (e.g. the ultrasonic alarm logic or a CPU register bridge) and the square-wave note generator, and is the only driver of that generator's note input.

## Interface
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 1000, duration tick rate; TICK_DIV = CLK_HZ/TICK_HZ cycles per tick, must be ≥ 2.
- DEPTH, 32, table entries, power of two; AW = log2(DEPTH).
- DUR_W, 10, duration field width, in ticks.
- GAP_TICKS, 10, silent articulation gap after each note, in ticks; 0 means no gap.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  table write strobe.
- wr_addr  in  AW  table write address.
- wr_note  in  7  note code: 0..28 are tones; 127 is a rest.
- wr_dur  in  DUR_W  duration in ticks; 0 is the end-of-sequence marker.
- start  in  1  start playback from address 0; single-cycle pulse.
- stop  in  1  abort playback; single-cycle pulse.
- loop_en  in  1  restart at address 0 on end-of-sequence.
- note_code  out  7  note index to the tone generator.
- tone_en  out  1  gates the tone generator output.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse on natural completion.
- cur_addr  out  AW  address of the entry being played.

## Operation
- States: IDLE, FETCH, PLAY, GAP.
- **IDLE**
  - A start pulse moves to FETCH with cur_addr=0.
  - If start and stop are high together, stop wins and the block stays in IDLE.
- **FETCH** (one cycle)
  - Reads table[cur_addr] into the latched note and duration.
  - If dur≠0, go to PLAY.
  - If dur=0 and loop_en=1 and cur_addr≠0, wrap to FETCH at address 0.
  - Otherwise go to IDLE and pulse done. This includes an empty table (dur=0 at address 0), even with loop_en set.
- **PLAY**
  - note_code = latched note.
  - tone_en = 1 unless note=127 (rest); for a rest, tone_en = 0 and note_code holds its previous value.
  - Lasts exactly dur×TICK_DIV cycles, then goes to GAP, or straight to the next-step logic if GAP_TICKS=0.
- **GAP**
  - tone_en = 0.
  - Lasts GAP_TICKS×TICK_DIV cycles, then goes to the next-step logic.
- **Next step**
  - If cur_addr=DEPTH-1, treat it as end-of-sequence and apply the FETCH dur=0 rules, with the loop target being address 0.
  - Otherwise cur_addr+1 and go to FETCH.
- **Stop**
  - A stop in any non-IDLE state moves to IDLE on the next edge.
  - tone_en falls on that edge; done is not pulsed.
  - A start in the same cycle is ignored.
- **Start while busy:** ignored.
- **Table writes**
  - Accepted in every state.
  - A write to the entry currently playing does not affect the current note; it takes effect on its next fetch.
  - A write on the same cycle as FETCH of the same address returns the old data.
- **Tick prescaler**
  - Cleared on entry to PLAY and to GAP, so durations are exact and independent of start phase.
- **Note codes:** values 29..126 are passed through unchanged; range checking is the host's responsibility.

## Timing
- Reset values: note_code=0, tone_en=0, busy=0, done=0, cur_addr=0, state=IDLE. Table contents are not reset.
- Start sampled at edge t:
  - busy=1 from t+1 (FETCH).
  - tone_en and note_code valid from t+2 (PLAY).
- Each entry occupies 1 + dur×TICK_DIV + GAP_TICKS×TICK_DIV cycles.
- tone_en is low during FETCH, giving a 1-cycle gap between notes even when GAP_TICKS=0.
- done and the falling edge of busy occur on the same edge.
- The loop wrap costs one extra FETCH cycle (the marker fetch); done is not pulsed on a wrap.
- Reset mid-operation returns all outputs to their reset values on the next edge.

## Structure
- Package melody_pkg holds:
  - REST_CODE=127 and NOTE_MAX=28;
  - the state enum;
  - the entry struct {note[6:0], dur[DUR_W-1:0]}, parameterised via a localparam default.
- Sub-module tick_prescaler:
  - inputs: clear, enable;
  - output: a one-cycle tick every TICK_DIV cycles.
- The table is a register array with a synchronous write port and a read port latched in FETCH. It is inferable as distributed RAM.

## Test plan
Benches use CLK_HZ=1000, TICK_HZ=100 (TICK_DIV=10), DEPTH=8, GAP_TICKS=1.
- Entries {9,3},{12,2},{0,0}, then start → note 9 with tone_en high for 30 cycles, 10 gap cycles, note 12 high for 20 cycles, 10 gap cycles, done pulse; busy is high for exactly 73 cycles.
- Entry {127,2} in the sequence → tone_en stays low for 20 cycles in PLAY; cur_addr advances normally.
- loop_en=1 with 2 entries plus marker → address sequence 0,1,2(marker),0,1…; done never pulses.
- Stop 5 cycles into the second note → busy and tone_en are 0 on the next edge, no done; a following start replays from address 0.
- Empty table (dur=0 at address 0) → busy high for 1 cycle, done pulses at t+2, tone_en never rises. Start and stop in the same cycle → nothing happens.
- All 8 entries non-zero → playback ends after address 7 with done; a write to address 1 while address 1 plays does not alter the current duration.
